// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect from
// execute, and the valid/ready hand-off to decode.
interface ifu_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            if_valid;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_out;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, instruction, pc_out,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, instruction, pc_out,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// in-order response buffer with PCs, and redirect flush/discard.
module ifu_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    ifu_fetch_if.master bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] instr_buf_q [BUF_DEPTH];
    logic [XLEN-1:0] instr_buf_d [BUF_DEPTH];
    logic [XLEN-1:0] pc_buf_q    [BUF_DEPTH];
    logic [XLEN-1:0] pc_buf_d    [BUF_DEPTH];

    logic [CW:0]     credit_used;
    logic            req_valid, if_valid, buf_nonempty;
    logic            req_fire, rsp_take, push, pop;
    logic [XLEN-1:0] redirect_tgt;
    logic            unused_redirect_lo;

    assign unused_redirect_lo = ^bus.redirect_pc[1:0];
    assign redirect_tgt       = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Buffered entries plus in-flight requests never exceed the buffer, so
    // every response always has a slot waiting for it.
    assign credit_used  = {1'b0, count_q} + {1'b0, outst_q};
    assign buf_nonempty = (count_q != '0);
    assign req_valid    = !rst && !bus.redirect_valid && (credit_used < (CW+1)'(BUF_DEPTH));
    assign if_valid     = !rst && buf_nonempty && !bus.redirect_valid;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.if_valid       = if_valid;
    assign bus.instruction    = buf_nonempty ? instr_buf_q[rd_ptr_q] : '0;
    assign bus.pc_out         = buf_nonempty ? pc_buf_q[rd_ptr_q] : '0;

    assign req_fire = req_valid && bus.imem_req_ready;
    assign rsp_take = bus.imem_rsp_valid && (outst_q != '0);
    assign pop      = if_valid && bus.id_ready;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        outst_d     = outst_q;
        discard_d   = discard_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        instr_buf_d = instr_buf_q;
        pc_buf_d    = pc_buf_q;
        push        = 1'b0;

        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            outst_d    = outst_q - CW'(rsp_take);
            // Every response still in flight is stale; pending discards are a
            // subset of outstanding, so the new discard count is just outst_d.
            discard_d  = outst_q - CW'(rsp_take);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            outst_d = outst_q + CW'(req_fire) - CW'(rsp_take);
            if (rsp_take) begin
                if (discard_q != '0) discard_d = discard_q - CW'(1);
                else                 push      = 1'b1;
            end
            if (push) begin
                instr_buf_d[wr_ptr_q] = bus.imem_rsp_data;
                pc_buf_d[wr_ptr_q]    = rsp_pc_q;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                rsp_pc_d              = rsp_pc_q + XLEN'(4);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                instr_buf_q[i] <= '0;
                pc_buf_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            instr_buf_q <= instr_buf_d;
            pc_buf_q    <= pc_buf_d;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a latency-varying memory model plus a
// scoreboard of the expected sequential {instruction, pc} stream.
module tb_ifu_fetch;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } exp_t;
    typedef struct { int due; logic [31:0] data; } mrsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_if #(.XLEN(XLEN)) bus ();

    ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    exp_t  exp_q[$];
    mrsp_t mem_q[$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] pend_addr = '0;
    logic        pend_valid = 1'b0;
    int cyc = 0, last_due = 0;
    int p_ready = 100, p_id = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        int lat, due;
        @(negedge clk);
        rst = 1'b0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.imem_req_ready = ($urandom_range(99) < p_ready);
        bus.id_ready       = ($urandom_range(99) < p_id);
        if (force_redir) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = force_pc;
            force_redir        = 1'b0;
        end else begin
            bus.redirect_valid = ($urandom_range(999) < p_redir);
            bus.redirect_pc    = $urandom;
        end
        #1;
        if (bus.redirect_valid) begin
            check("redir_no_req", bus.imem_req_valid, 0);
            check("redir_no_ifvalid", bus.if_valid, 0);
            exp_q.delete();
            model_pc = {bus.redirect_pc[31:2], 2'b00};
        end
        if (pend_valid && !bus.redirect_valid) begin
            check("req_hold_valid", bus.imem_req_valid, 1);
            check("req_hold_addr", bus.imem_req_addr, pend_addr);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, model_pc);
            lat = $urandom_range(lat_max, lat_min);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mem_q.push_back('{due, mem_word(bus.imem_req_addr)});
            exp_q.push_back('{mem_word(model_pc), model_pc});
            model_pc += 32'd4;
        end
        pend_valid = bus.imem_req_valid && !bus.imem_req_ready;
        pend_addr  = bus.imem_req_addr;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst = 1'b1;
            bus.imem_rsp_valid = 1'b0;
            bus.redirect_valid = 1'b0;
            bus.imem_req_ready = 1'b1;
            bus.id_ready       = 1'b1;
            #1;
            check("rst_req_valid", bus.imem_req_valid, 0);
            check("rst_if_valid", bus.if_valid, 0);
            if (k > 0) begin
                check("rst_instruction", bus.instruction, 0);
                check("rst_pc_out", bus.pc_out, 0);
            end
            cyc++;
        end
        mem_q.delete();
        exp_q.delete();
        model_pc   = RESET_PC;
        pend_valid = 1'b0;
        last_due   = cyc;
    endtask

    // Monitor: every delivery to decode must be the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && bus.if_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h expected no delivery", bus.pc_out);
            end else begin
                e = exp_q.pop_front();
                check("pc_out", bus.pc_out, e.pc);
                check("instruction", bus.instruction, e.instr);
            end
        end
    end

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;

        do_reset(3);
        run(3);
        check("first_valid_cycle2", bus.if_valid, 1);
        check("first_pc_cycle2", bus.pc_out, RESET_PC);
        run(20);

        p_id = 0;
        run(6);
        check("stall_no_req", bus.imem_req_valid, 0);
        check("stall_if_valid", bus.if_valid, 1);
        p_id = 100;
        run(10);

        lat_min = 3; lat_max = 3;
        run(4);
        force_redir = 1'b1; force_pc = 32'h0000_0100;
        run(15);
        force_redir = 1'b1; force_pc = 32'h0000_0203;
        run(12);

        lat_min = 1; lat_max = 1;
        do_reset(2);
        p_ready = 0;
        run(5);
        check("held_addr", bus.imem_req_addr, RESET_PC);
        p_ready = 100;
        run(10);

        force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
        run(10);

        p_id = 0;
        run(6);
        do_reset(2);
        p_id = 100;
        run(3);
        check("restart_valid", bus.if_valid, 1);
        check("restart_pc", bus.pc_out, RESET_PC);

        for (int blk = 0; blk < 60; blk++) begin
            p_ready = $urandom_range(100, 30);
            p_id    = $urandom_range(100, 30);
            p_redir = $urandom_range(40, 0);
            lat_max = $urandom_range(4, 1);
            run(50);
        end

        p_redir = 0; p_ready = 0; p_id = 100;
        run(14);
        check("drain_exp_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
